// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer: fixed yellow/all-red clearances, minimum main green,
// latched side/pedestrian demand served with a fixed side-green interval.
module intersection_phase_scheduler #(
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned MAIN_MIN   = 15,
  parameter int unsigned SIDE_GRN   = 10,
  parameter int unsigned YELLOW_CYC = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       side_req,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic [2:0] phase,
  output logic       req_pending
);

  typedef enum logic [2:0] {
    AR_M = 3'd0,
    MG   = 3'd1,
    MY   = 3'd2,
    AR_S = 3'd3,
    SG   = 3'd4,
    SY   = 3'd5
  } phase_t;

  localparam logic [CNT_W-1:0] ALLRED_N = CNT_W'(ALLRED_CYC);
  localparam logic [CNT_W-1:0] MIN_N    = CNT_W'(MAIN_MIN);
  localparam logic [CNT_W-1:0] SIDE_N   = CNT_W'(SIDE_GRN);
  localparam logic [CNT_W-1:0] YELLOW_N = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] ONE_N    = CNT_W'(1);

  phase_t           state_q;
  phase_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             latch_d;
  logic [5:0]       lamps_d;

  // Phase sequencing; cnt_q holds cycles spent in the phase including the current one
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AR_M:    if (cnt_q == ALLRED_N) state_d = MG;
      MG:      if ((cnt_q >= MIN_N) && req_pending) state_d = MY;
      MY:      if (cnt_q == YELLOW_N) state_d = AR_S;
      AR_S:    if (cnt_q == ALLRED_N) state_d = SG;
      SG:      if (cnt_q == SIDE_N) state_d = SY;
      SY:      if (cnt_q == YELLOW_N) state_d = AR_M;
      default: state_d = AR_M;
    endcase
  end

  // Counter reloads on phase entry and saturates while main green rests
  always_comb begin
    cnt_d = cnt_q + ONE_N;
    if (state_d != state_q) begin
      cnt_d = ONE_N;
    end else if ((state_q == MG) && (cnt_q >= MIN_N)) begin
      cnt_d = MIN_N;
    end
  end

  // Demand latch: entering side green clears it, and that clear beats a same-edge set
  always_comb begin
    latch_d = req_pending;
    if ((state_d == SG) && (state_q != SG)) begin
      latch_d = 1'b0;
    end else if (side_req && (state_q != SG)) begin
      latch_d = 1'b1;
    end
  end

  // Lamp pattern {main r,y,g, side r,y,g} of the phase being entered
  always_comb begin
    lamps_d = 6'b100_100;
    unique case (state_d)
      AR_M:    lamps_d = 6'b100_100;
      MG:      lamps_d = 6'b001_100;
      MY:      lamps_d = 6'b010_100;
      AR_S:    lamps_d = 6'b100_100;
      SG:      lamps_d = 6'b100_001;
      SY:      lamps_d = 6'b100_010;
      default: lamps_d = 6'b100_100;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= AR_M;
      cnt_q       <= '0;
      req_pending <= 1'b0;
      main_red    <= 1'b1;
      main_yellow <= 1'b0;
      main_green  <= 1'b0;
      side_red    <= 1'b1;
      side_yellow <= 1'b0;
      side_green  <= 1'b0;
      walk        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_pending <= latch_d;
      main_red    <= lamps_d[5];
      main_yellow <= lamps_d[4];
      main_green  <= lamps_d[3];
      side_red    <= lamps_d[2];
      side_yellow <= lamps_d[1];
      side_green  <= lamps_d[0];
      walk        <= lamps_d[0];
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenario table plus a random sweep
// against a schedule-offset reference model and per-cycle safety checks.
module tb_intersection_phase_scheduler;

  localparam int A    = 2;
  localparam int MMIN = 15;
  localparam int S    = 10;
  localparam int Y    = 5;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       side_req = 1'b0;
  logic       main_red, main_yellow, main_green;
  logic       side_red, side_yellow, side_green;
  logic       walk;
  logic [2:0] phase;
  logic       req_pending;

  always #5 clock = ~clock;

  intersection_phase_scheduler #(
    .ALLRED_CYC(A), .MAIN_MIN(MMIN), .SIDE_GRN(S), .YELLOW_CYC(Y), .CNT_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .side_req(side_req),
    .main_red(main_red), .main_yellow(main_yellow), .main_green(main_green),
    .side_red(side_red), .side_yellow(side_yellow), .side_green(side_green),
    .walk(walk), .phase(phase), .req_pending(req_pending)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time since AR_M start (m_arm) and since service start (m_svc)
  int m_t   = 0;
  int m_arm = 1;
  int m_svc = -1;
  bit m_latch = 1'b0;

  function automatic int model_phase(input int t, input int arm, input int svc);
    int d;
    if (svc < 0 || t < svc) begin
      d = t - arm;
      return (d < A) ? 0 : 1;
    end
    d = t - svc;
    if (d < Y) return 2;
    if (d < Y + A) return 3;
    if (d < Y + A + S) return 4;
    return 5;
  endfunction

  function automatic logic [6:0] lamps_of(input int ph);
    case (ph)
      1:       return 7'b001_100_0;
      2:       return 7'b010_100_0;
      4:       return 7'b100_001_1;
      5:       return 7'b100_010_0;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic model_step(input bit req, input bit rst);
    int cur;
    int nxt;
    if (!rst) begin
      m_t = 0; m_arm = 1; m_svc = -1; m_latch = 1'b0;
      return;
    end
    cur = model_phase(m_t, m_arm, m_svc);
    if (cur == 1 && m_latch && (m_t - (m_arm + A) + 1) >= MMIN) m_svc = m_t + 1;
    if (m_svc >= 0 && (m_t + 1 - m_svc) == 2 * Y + A + S) begin
      m_arm = m_t + 1;
      m_svc = -1;
    end
    m_t++;
    nxt = model_phase(m_t, m_arm, m_svc);
    if (nxt == 4 && cur != 4) m_latch = 1'b0;
    else if (req && cur != 4) m_latch = 1'b1;
  endtask

  task automatic check_model();
    logic [10:0] act;
    logic [10:0] exp;
    int p;
    p   = model_phase(m_t, m_arm, m_svc);
    exp = {lamps_of(p), 3'(p), m_latch};
    act = {main_red, main_yellow, main_green, side_red, side_yellow, side_green,
           walk, phase, req_pending};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL model t=%0d: got %b required %b", m_t, act, exp);
    end
  endtask

  task automatic check_inv();
    n_vec++;
    if (!$onehot({main_red, main_yellow, main_green})) begin
      n_err++;
      $display("FAIL main_onehot: got %b", {main_red, main_yellow, main_green});
    end
    n_vec++;
    if (!$onehot({side_red, side_yellow, side_green})) begin
      n_err++;
      $display("FAIL side_onehot: got %b", {side_red, side_yellow, side_green});
    end
    n_vec++;
    if (!(main_red || side_red)) begin
      n_err++;
      $display("FAIL one_red: got main_red=%b side_red=%b required one set", main_red, side_red);
    end
  endtask

  int run_ph    = -1;
  int run_len   = 0;
  bit run_clean = 1'b0;

  task automatic track_len(input bit rs);
    int ph;
    bit ok;
    ph = int'(phase);
    if (!rs) begin
      run_ph = ph; run_len = 1; run_clean = 1'b0;
    end else if (ph == run_ph) begin
      run_len++;
    end else begin
      if (run_clean) begin
        case (run_ph)
          0, 3:    ok = (run_len == A);
          2, 5:    ok = (run_len == Y);
          4:       ok = (run_len == S);
          1:       ok = (run_len >= MMIN);
          default: ok = 1'b0;
        endcase
        n_vec++;
        if (!ok) begin
          n_err++;
          $display("FAIL phase_len ph=%0d: got %0d cycles", run_ph, run_len);
        end
      end
      run_ph = ph; run_len = 1; run_clean = 1'b1;
    end
  endtask

  task automatic tick();
    bit r;
    bit rs;
    r  = side_req;
    rs = reset_n;
    @(posedge clock);
    model_step(r, rs);
    #1;
    check_model();
    check_inv();
    track_len(rs);
  endtask

  typedef struct {
    int         scen;
    int         k;
    bit         drv_req;
    bit         drv_rst;
    bit         chk;
    logic [2:0] ph;
    logic       pend;
    logic       walk;
  } vec_t;

  vec_t vecs[$];
  int   scen_len[6] = '{200, 60, 120, 80, 70, 60};

  function automatic void add_chk(input int s, input int k, input int ph, input bit pend, input bit w);
    vecs.push_back('{s, k, 1'b0, 1'b0, 1'b1, 3'(ph), pend, w});
  endfunction

  function automatic void add_req(input int s, input int k);
    vecs.push_back('{s, k, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
  endfunction

  function automatic void add_rst(input int s, input int k);
    vecs.push_back('{s, k, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
  endfunction

  task automatic do_reset();
    reset_n  = 1'b0;
    side_req = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({main_red, side_red, phase, walk} !== 6'b11_000_0) begin
      n_err++;
      $display("FAIL in_reset: got reds=%b%b phase=%0d walk=%b required 11/0/0",
               main_red, side_red, phase, walk);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    // Scenario 0: idle
    add_chk(0, 1, 0, 0, 0);  add_chk(0, 2, 0, 0, 0);  add_chk(0, 3, 1, 0, 0);
    add_chk(0, 17, 1, 0, 0); add_chk(0, 200, 1, 0, 0);
    // Scenario 1: early request
    add_req(1, 5);
    add_chk(1, 5, 1, 0, 0);  add_chk(1, 6, 1, 1, 0);  add_chk(1, 17, 1, 1, 0);
    add_chk(1, 18, 2, 1, 0); add_chk(1, 22, 2, 1, 0); add_chk(1, 23, 3, 1, 0);
    add_chk(1, 24, 3, 1, 0); add_chk(1, 25, 4, 0, 1); add_chk(1, 34, 4, 0, 1);
    add_chk(1, 35, 5, 0, 0); add_chk(1, 39, 5, 0, 0); add_chk(1, 40, 0, 0, 0);
    add_chk(1, 41, 0, 0, 0); add_chk(1, 42, 1, 0, 0); add_chk(1, 60, 1, 0, 0);
    // Scenario 2: late request
    add_req(2, 100);
    add_chk(2, 100, 1, 0, 0); add_chk(2, 101, 1, 1, 0); add_chk(2, 102, 2, 1, 0);
    add_chk(2, 106, 2, 1, 0); add_chk(2, 107, 3, 1, 0); add_chk(2, 109, 4, 0, 1);
    // Scenario 3: demand during SG is ignored
    add_req(3, 5);
    for (int k = 26; k <= 30; k++) add_req(3, k);
    add_chk(3, 27, 4, 0, 1); add_chk(3, 31, 4, 0, 1); add_chk(3, 42, 1, 0, 0);
    add_chk(3, 80, 1, 0, 0);
    // Scenario 4: demand during SY is held
    add_req(4, 5); add_req(4, 36);
    add_chk(4, 36, 5, 0, 0); add_chk(4, 37, 5, 1, 0); add_chk(4, 42, 1, 1, 0);
    add_chk(4, 56, 1, 1, 0); add_chk(4, 57, 2, 1, 0);
    // Scenario 5: reset mid side green
    add_req(5, 5); add_rst(5, 28);
    add_chk(5, 28, 4, 0, 1); add_chk(5, 29, 0, 0, 0); add_chk(5, 30, 0, 0, 0);
    add_chk(5, 31, 0, 0, 0); add_chk(5, 32, 1, 0, 0); add_chk(5, 46, 1, 0, 0);
    add_chk(5, 60, 1, 0, 0);

    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int k = 1; k <= scen_len[s]; k++) begin
        bit r;
        bit rl;
        tick();
        r  = 1'b0;
        rl = 1'b0;
        foreach (vecs[i]) begin
          if (vecs[i].scen == s && vecs[i].k == k) begin
            if (vecs[i].drv_req) r = 1'b1;
            if (vecs[i].drv_rst) rl = 1'b1;
            if (vecs[i].chk) begin
              n_vec++;
              if ({phase, req_pending, walk} !== {vecs[i].ph, vecs[i].pend, vecs[i].walk}) begin
                n_err++;
                $display("FAIL vec s=%0d k=%0d: got ph=%0d pend=%b walk=%b required ph=%0d pend=%b walk=%b",
                         s, k, phase, req_pending, walk, vecs[i].ph, vecs[i].pend, vecs[i].walk);
              end
            end
          end
        end
        side_req = r;
        reset_n  = ~rl;
      end
    end

    // Random sweep of demand and occasional resets
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      side_req = ($urandom_range(0, 3) == 0);
      reset_n  = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
